// File: rtl/clock_pkg.sv
// Shared encodings, limits and field widths for the digital clock.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2
  } mode_e;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  // Mode key cycles RUN -> SET_HOUR -> SET_MIN -> RUN.
  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    case (cur)
      MODE_RUN:      nxt = MODE_SET_HOUR;
      MODE_SET_HOUR: nxt = MODE_SET_MIN;
      default:       nxt = MODE_RUN;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) up/down counter with synchronous clear and increment carry.
module mod_counter #(
  parameter int unsigned MAX   = 59,
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX);

  logic [WIDTH-1:0] value_d, value_q;
  logic             step_up, step_dn;

  // inc and dec together cancel out.
  assign step_up = inc && !dec;
  assign step_dn = dec && !inc;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (step_up) begin
      value_d = (value_q == MaxV) ? '0 : value_q + 1'b1;
    end else if (step_dn) begin
      value_d = (value_q == '0) ? MaxV : value_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  // Combinational so the next field advances on the same edge as this one wraps.
  assign carry = step_up && !clr && (value_q == MaxV);
  assign value = value_q;

endmodule

// File: rtl/clock_time_core.sv
// Timekeeping and time-set core: 1 Hz prescaler, RUN/SET_HOUR/SET_MIN FSM, h:m:s fields.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode_flag,
  input  logic              mode_key,
  input  logic              up_flag,
  input  logic              up_key,
  input  logic              down_flag,
  input  logic              down_key,
  output logic [HOUR_W-1:0] hour,
  output logic [MIN_W-1:0]  minute,
  output logic [SEC_W-1:0]  second,
  output logic [1:0]        set_mode,
  output logic              blink,
  output logic              sec_tick
);

  localparam int unsigned     PS_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(CLK_HZ / 2);

  mode_e           mode_q, mode_d;
  logic [PS_W-1:0] ps_q;
  logic            sec_tick_q, blink_q;

  logic mode_press, up_press, down_press;
  logic adj_up, adj_dn;
  logic ps_wrap, exit_set;
  logic in_run, in_set_hour, in_set_min;

  logic sec_inc, min_inc, min_dec, hour_inc, hour_dec;
  logic sec_carry, min_carry, hour_carry;

  // A flag with the key level high is a release edge and carries no action.
  assign mode_press = mode_flag && !mode_key;
  assign up_press   = up_flag && !up_key;
  assign down_press = down_flag && !down_key;

  // A mode press wins over any adjust press in the same cycle.
  assign adj_up = up_press && !mode_press;
  assign adj_dn = down_press && !mode_press;

  assign in_run      = (mode_q == MODE_RUN);
  assign in_set_hour = (mode_q == MODE_SET_HOUR);
  assign in_set_min  = (mode_q == MODE_SET_MIN);

  assign ps_wrap  = (ps_q == PS_LAST);
  assign exit_set = in_set_min && mode_press;

  always_comb begin
    mode_d = mode_q;
    if (mode_press) begin
      mode_d = next_mode(mode_q);
    end
  end

  always_comb begin
    sec_inc  = in_run && ps_wrap;
    min_inc  = in_run ? sec_carry : (in_set_min && adj_up);
    min_dec  = in_set_min && adj_dn;
    hour_inc = in_run ? min_carry : (in_set_hour && adj_up);
    hour_dec = in_set_hour && adj_dn;
  end

  // Mode register, prescaler and the registered tick/blink outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_RUN;
      ps_q       <= '0;
      sec_tick_q <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      sec_tick_q <= ps_wrap;
      // Next-state mode keeps blink low in every cycle that shows RUN.
      blink_q    <= (mode_d != MODE_RUN) && (ps_q < PS_HALF);
      if (exit_set || ps_wrap) begin
        ps_q <= '0;
      end else begin
        ps_q <= ps_q + 1'b1;
      end
    end
  end

  mod_counter #(
    .MAX   (SEC_MAX),
    .WIDTH (SEC_W)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .dec   (1'b0),
    .clr   (exit_set),
    .value (second),
    .carry (sec_carry)
  );

  mod_counter #(
    .MAX   (MIN_MAX),
    .WIDTH (MIN_W)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .dec   (min_dec),
    .clr   (1'b0),
    .value (minute),
    .carry (min_carry)
  );

  mod_counter #(
    .MAX   (HOUR_MAX),
    .WIDTH (HOUR_W)
  ) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hour_inc),
    .dec   (hour_dec),
    .clr   (1'b0),
    .value (hour),
    .carry (hour_carry)
  );

  // Hour wrap has no consumer; a day rollover needs no further carry.
  logic unused_hour_carry;
  assign unused_hour_carry = hour_carry;

  assign set_mode = mode_q;
  assign blink    = blink_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Scoreboard bench for clock_time_core at CLK_HZ=10.
module tb_clock_time_core;

  localparam int CLK_HZ = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode_flag = 1'b0, mode_key = 1'b1;
  logic       up_flag = 1'b0, up_key = 1'b1;
  logic       down_flag = 1'b0, down_key = 1'b1;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [1:0] set_mode;
  logic       blink, sec_tick;

  clock_time_core #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_flag (mode_flag),
    .mode_key  (mode_key),
    .up_flag   (up_flag),
    .up_key    (up_key),
    .down_flag (down_flag),
    .down_key  (down_key),
    .hour      (hour),
    .minute    (minute),
    .second    (second),
    .set_mode  (set_mode),
    .blink     (blink),
    .sec_tick  (sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] mode;
    logic       blink;
    logic       tick;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int mh, mm, ms, mmode, mps;

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mmode = 0; mps = 0;
    sb.delete();
  endtask

  // Empty queue yields impossible values so any compare against it fails.
  function automatic exp_t pop_exp();
    exp_t e;
    e = '{h: 5'd31, m: 6'd63, s: 6'd63, mode: 2'd3, blink: 1'bx, tick: 1'bx};
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  task automatic cycle(input bit mf, input bit mk, input bit uf, input bit uk,
                       input bit df, input bit dk);
    bit   mp, upp, dnp, wrap, ex;
    int   nmode;
    exp_t e;
    mode_flag = mf; mode_key = mk; up_flag = uf; up_key = uk;
    down_flag = df; down_key = dk;
    mp   = mf && !mk;
    upp  = uf && !uk;
    dnp  = df && !dk;
    wrap = (mps == CLK_HZ - 1);
    ex   = (mmode == 2) && mp;
    nmode = mp ? ((mmode + 1) % 3) : mmode;
    if (mmode == 0 && wrap) begin
      ms = ms + 1;
      if (ms == 60) begin
        ms = 0; mm = mm + 1;
        if (mm == 60) begin mm = 0; mh = (mh + 1) % 24; end
      end
    end else if (mmode == 1 && !mp && upp != dnp) begin
      mh = upp ? (mh + 1) % 24 : (mh + 23) % 24;
    end else if (mmode == 2 && !mp && upp != dnp) begin
      mm = upp ? (mm + 1) % 60 : (mm + 59) % 60;
    end
    if (ex) ms = 0;
    e.blink = (nmode != 0) && (mps < CLK_HZ / 2);
    e.tick  = wrap;
    mps   = (ex || wrap) ? 0 : mps + 1;
    mmode = nmode;
    e.h = 5'(mh); e.m = 6'(mm); e.s = 6'(ms); e.mode = 2'(mmode);
    sb.push_back(e);
    @(posedge clk);
    #1;
    mode_flag = 1'b0; mode_key = 1'b1; up_flag = 1'b0; up_key = 1'b1;
    down_flag = 1'b0; down_key = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   first_tick;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({hour, minute, second, set_mode, blink, sec_tick} !== '0) begin
      errors++;
      $display("FAIL por_reset got %0d:%0d:%0d mode %0d blink %b tick %b want all 0",
               hour, minute, second, set_mode, blink, sec_tick);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cycle(0, 1, 0, 1, 0, 1);
      e = pop_exp();
      checks++;
      if (sec_tick !== e.tick || second !== e.s) begin
        errors++;
        $display("FAIL run_pre_reset got tick %b sec %0d want tick %b sec %0d",
                 sec_tick, second, e.tick, e.s);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({hour, minute, second, set_mode, blink, sec_tick} !== '0) begin
      errors++;
      $display("FAIL async_reset_run got %0d:%0d:%0d mode %0d blink %b tick %b want all 0",
               hour, minute, second, set_mode, blink, sec_tick);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    first_tick = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 1, 0, 1, 0, 1);
      e = pop_exp();
      checks++;
      if (sec_tick !== e.tick || second !== e.s || blink !== e.blink) begin
        errors++;
        $display("FAIL post_reset_cycle%0d got tick %b sec %0d blink %b want %b %0d %b",
                 i, sec_tick, second, blink, e.tick, e.s, e.blink);
      end
      if (sec_tick === 1'b1 && first_tick == 0) first_tick = i;
      if (i == 10) begin
        checks++;
        if (second !== 6'd1) begin
          errors++;
          $display("FAIL first_second got %0d want 1", second);
        end
      end
    end
    checks++;
    if (first_tick != CLK_HZ) begin
      errors++;
      $display("FAIL first_tick_latency got %0d want %0d", first_tick, CLK_HZ);
    end
  endtask

  task automatic test_set_rollover();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) cycle(1, 0, 0, 1, 0, 1);
      else cycle(0, 1, 0, 1, 1, 0);
      e = pop_exp();
      checks++;
      if (hour !== e.h || minute !== e.m || second !== e.s || set_mode !== e.mode) begin
        errors++;
        $display("FAIL set_step%0d got %0d:%0d:%0d mode %0d want %0d:%0d:%0d mode %0d",
                 i, hour, minute, second, set_mode, e.h, e.m, e.s, e.mode);
      end
    end
    checks++;
    if (hour !== 5'd23 || minute !== 6'd59 || second !== 6'd0 || set_mode !== 2'd0) begin
      errors++;
      $display("FAIL set_result got %0d:%0d:%0d mode %0d want 23:59:0 mode 0",
               hour, minute, second, set_mode);
    end
    for (int i = 0; i < 60 * CLK_HZ; i++) begin
      cycle(0, 1, 0, 1, 0, 1);
      e = pop_exp();
      checks++;
      if (hour !== e.h || minute !== e.m || second !== e.s || sec_tick !== e.tick ||
          blink !== e.blink || hour > 5'd23 || minute > 6'd59) begin
        errors++;
        $display("FAIL rollover_cycle%0d got %0d:%0d:%0d tick %b blink %b want %0d:%0d:%0d %b %b",
                 i, hour, minute, second, sec_tick, blink, e.h, e.m, e.s, e.tick, e.blink);
      end
    end
    checks++;
    if (hour !== 5'd0 || minute !== 6'd0 || second !== 6'd0) begin
      errors++;
      $display("FAIL midnight got %0d:%0d:%0d want 0:0:0", hour, minute, second);
    end
  endtask

  task automatic test_release_filter();
    exp_t e;
    cycle(1, 0, 0, 1, 0, 1);
    e = pop_exp();
    checks++;
    if (set_mode !== e.mode) begin
      errors++;
      $display("FAIL enter_set_hour got %0d want %0d", set_mode, e.mode);
    end
    cycle(0, 1, 1, 1, 0, 1);
    e = pop_exp();
    checks++;
    if (hour !== e.h || hour !== 5'd0) begin
      errors++;
      $display("FAIL release_ignored got hour %0d want %0d", hour, e.h);
    end
    cycle(0, 1, 1, 0, 0, 1);
    e = pop_exp();
    checks++;
    if (hour !== e.h || hour !== 5'd1) begin
      errors++;
      $display("FAIL up_press_hour got %0d want %0d", hour, e.h);
    end
  endtask

  task automatic test_simultaneity();
    exp_t e;
    cycle(1, 0, 1, 0, 0, 1);
    e = pop_exp();
    checks++;
    if (set_mode !== 2'd2 || hour !== e.h || set_mode !== e.mode) begin
      errors++;
      $display("FAIL mode_with_up got mode %0d hour %0d want mode %0d hour %0d",
               set_mode, hour, e.mode, e.h);
    end
    cycle(0, 1, 1, 0, 1, 0);
    e = pop_exp();
    checks++;
    if (minute !== e.m || minute !== 6'd0) begin
      errors++;
      $display("FAIL up_down_same got minute %0d want %0d", minute, e.m);
    end
  endtask

  task automatic test_hold_in_set();
    exp_t e;
    int   ticks;
    cycle(1, 0, 0, 1, 0, 1);
    e = pop_exp();
    checks++;
    if (set_mode !== e.mode || second !== e.s || blink !== e.blink) begin
      errors++;
      $display("FAIL exit_to_run got mode %0d sec %0d blink %b want %0d %0d %b",
               set_mode, second, blink, e.mode, e.s, e.blink);
    end
    cycle(1, 0, 0, 1, 0, 1);
    e = pop_exp();
    ticks = 0;
    for (int i = 0; i < 3 * CLK_HZ; i++) begin
      cycle(0, 1, 0, 1, 0, 1);
      e = pop_exp();
      if (sec_tick === 1'b1) ticks++;
      checks++;
      if (blink !== e.blink || second !== e.s || sec_tick !== e.tick || hour !== e.h) begin
        errors++;
        $display("FAIL hold_cycle%0d got blink %b sec %0d tick %b hour %0d want %b %0d %b %0d",
                 i, blink, second, sec_tick, hour, e.blink, e.s, e.tick, e.h);
      end
    end
    checks++;
    if (ticks != 3 || second !== 6'd0) begin
      errors++;
      $display("FAIL hold_summary got ticks %0d sec %0d want 3 0", ticks, second);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit   seen;
    cycle(1, 0, 0, 1, 0, 1);
    e = pop_exp();
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 1, 0, 0, 1);
      e = pop_exp();
      checks++;
      if (minute !== e.m || set_mode !== e.mode) begin
        errors++;
        $display("FAIL back_to_back%0d got minute %0d mode %0d want %0d %0d",
                 i, minute, set_mode, e.m, e.mode);
      end
    end
    checks++;
    if (minute !== 6'd17 || set_mode !== 2'd2) begin
      errors++;
      $display("FAIL minute17 got minute %0d mode %0d want 17 2", minute, set_mode);
    end
    seen = 1'b0;
    for (int i = 0; i < 2 * CLK_HZ && !seen; i++) begin
      cycle(0, 1, 0, 1, 0, 1);
      e = pop_exp();
      seen = (e.blink === 1'b1);
    end
    checks++;
    if (!seen || blink !== 1'b1) begin
      errors++;
      $display("FAIL blink_before_reset got %b want 1", blink);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (set_mode !== 2'd0 || minute !== 6'd0 || blink !== 1'b0 || hour !== 5'd0 ||
        second !== 6'd0 || sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_set got mode %0d minute %0d blink %b want 0 0 0",
               set_mode, minute, blink);
    end
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set_rollover();
    test_release_filter();
    test_simultaneity();
    test_hold_in_set();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
# clock_time_core

Timekeeping and time-set core of the digital clock. Consumes the one-cycle debounced key flags from the key filters for the mode, up and down keys, together with each key's synchronized level. Maintains hours/minutes/seconds from a 1 Hz prescaler and runs a RUN / SET_HOUR / SET_MIN mode state machine. Outputs feed the display driver: binary time fields, a field-select code and a blink enable.

## Interface
- CLK_HZ, 50_000_000: clk frequency in Hz; one second is CLK_HZ cycles; must be ≥ 2.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- mode_flag  in  1  one-cycle debounced-event pulse, mode key (fires on press and release)
- mode_key  in  1  mode key level; 0 = pressed
- up_flag  in  1  debounced-event pulse, up key
- up_key  in  1  up key level; 0 = pressed
- down_flag  in  1  debounced-event pulse, down key
- down_key  in  1  down key level; 0 = pressed
- hour  out  5  hours, 0–23
- minute  out  6  minutes, 0–59
- second  out  6  seconds, 0–59
- set_mode  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN; 3 is never driven
- blink  out  1  display blank-enable for the field being set
- sec_tick  out  1  one-cycle pulse per elapsed second

## Operation
- Press qualification: a press is `x_flag == 1 && x_key == 0` in the same cycle. A flag with the key level at 1 is a release and is ignored.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps; runs in every mode.
  - Restarts at 0 on the SET_MIN→RUN transition.
- FSM:
  - Mode press steps RUN→SET_HOUR→SET_MIN→RUN.
  - set_mode is the state register.
- RUN:
  - On prescaler wrap, second increments.
  - 59→0 carries to minute; minute 59→0 carries to hour; hour 23→0.
  - 23:59:59 → 00:00:00 in a single tick.
- SET_HOUR:
  - Time does not advance.
  - Up press: hour+1, 23→0. Down press: hour-1, 0→23.
- SET_MIN:
  - Time does not advance.
  - Up/down adjust minute with wrap 59↔0.
  - Hour never changes from a minute wrap.
- Exit SET_MIN→RUN: second cleared to 0 and prescaler cleared, on the same edge.
- Simultaneous events:
  - Mode press together with up/down: the mode transition occurs; up/down are ignored that cycle.
  - Up and down pressed in the same cycle: no change.
  - Up/down presses in RUN are ignored.
- blink:
  - 1 when set_mode ≠ 0 and prescaler < CLK_HZ/2; else 0.
  - In RUN, blink is 0.
- Reset (any time, including mid-SET): hour=minute=second=0, set_mode=0, blink=0, sec_tick=0, prescaler=0.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Press in cycle N → updated hour/minute/set_mode visible after the clk edge ending cycle N (1-cycle latency).
- sec_tick is high for exactly the one cycle after the edge where the prescaler wraps. Time fields change on that same edge, so the new value and sec_tick appear together.
- sec_tick is asserted in every mode; time increments only in RUN.
- First sec_tick after reset: CLK_HZ cycles after rst_n deasserts.
- blink is registered from the prescaler compare and lags the prescaler by 1 cycle.

## Structure
- Shared package/header `clock_pkg`: mode encodings MODE_RUN=2'd0, MODE_SET_HOUR=2'd1, MODE_SET_MIN=2'd2; limits HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59; field widths 5/6/6.
- Sub-module `mod_counter`:
  - Parameters: MAX, WIDTH.
  - Inputs: inc, dec, clr.
  - Outputs: value, carry on MAX→0 increment.
  - inc and dec both high = hold.
  - Instantiated three times (second, minute, hour). Carry chaining and mode gating live in the top.
- Prescaler and FSM live in the top.

## Test plan
All scenarios use CLK_HZ=10.
- Reset: assert rst_n=0 mid-run → all outputs 0 immediately. Release → sec_tick first high 10 cycles later, then second=1.
- Set and rollover:
  - Stimulus: mode press; 1 down press (hour 0→23); mode press; 1 down press (minute 0→59); mode press → 23:59:00, set_mode=0.
  - Then 60 ticks → 00:00:00 with no intermediate hour=24 or minute=60.
- Release filtering: up_flag=1 with up_key=1 in SET_HOUR → hour unchanged. up_flag=1 with up_key=0 → hour+1 one cycle later.
- Simultaneity:
  - Up and down pressed in the same cycle in SET_MIN → minute unchanged.
  - Mode and up in the same cycle in SET_HOUR → set_mode=2, hour unchanged.
- Hold in SET: in SET_HOUR run 30 cycles → sec_tick pulses 3 times, second unchanged. blink is 1 for prescaler 0–4 and 0 for 5–9, lagged 1 cycle.
- Reset mid-operation: rst_n low while set_mode=2, minute=17 → set_mode=0, minute=0, blink=0 asynchronously.
